// File: rtl/snd_host_port.sv
// snd_host_port: 68k-side sound mailbox initiator with command/reply FIFOs.
// Optional watchdog enabled by defining SND_HOST_TIMEOUT_EN.
module snd_host_port #(
    parameter int CMD_DEPTH   = 4,
    parameter int REP_DEPTH   = 4,
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 8,
    parameter int RECOVER_CYC = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk100,
    input  logic       rst_b,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rep_data,
    output logic       rep_valid,
    input  logic       rep_pop,
    output logic [7:0] Dout68k,
    input  logic [7:0] Din68k,
    output logic       SNDWR_b,
    output logic       SNDRD_b,
    input  logic       ctrl_SNDBUF,
    input  logic       SNDINT_b,
    output logic       busy,
    output logic       cmd_timeout,
    input  logic       err_clr
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(REP_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int CW  = $clog2(SETUP_CYC + STROBE_CYC + RECOVER_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_RD_STROBE,
        S_RECOVER
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_dout;
    logic            r_wr_b;
    logic            r_rd_b;
    logic            r_busy;
    logic            r_buf_s1, r_buf_s2;
    logic            r_int_s1, r_int_s2;

    logic [7:0]      r_cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]  r_cmd_wp, r_cmd_rp;
    logic [CCW-1:0]  r_cmd_cnt;
    logic            r_cmd_ready;

    logic [7:0]      r_rep_mem [REP_DEPTH];
    logic [RPW-1:0]  r_rep_wp, r_rep_rp;
    logic [RCW-1:0]  r_rep_cnt;
    logic            r_rep_valid;
    logic [7:0]      r_rep_data;

    logic            w_idle, w_rd_go, w_wr_go, w_flush;
    logic            w_end_setup, w_end_strobe, w_end_recover;
    logic            w_cmd_push, w_cmd_pop, w_rep_push, w_rep_pop;
    logic [CCW-1:0]  w_cmd_cnt_n;
    logic [RCW-1:0]  w_rep_cnt_n;
    logic [RPW-1:0]  w_rep_rp_n;
    logic [7:0]      w_rep_head_n;

    assign w_idle        = (r_state == S_IDLE);
    assign w_rd_go       = w_idle & ~r_int_s2 & (r_rep_cnt != RCW'(REP_DEPTH));
    assign w_wr_go       = w_idle & ~w_rd_go & (r_cmd_cnt != '0) & ~r_buf_s2;
    assign w_end_setup   = (r_cnt == CW'(SETUP_CYC - 1));
    assign w_end_strobe  = (r_cnt == CW'(STROBE_CYC - 1));
    assign w_end_recover = (r_cnt == CW'(RECOVER_CYC - 1));
    assign w_cmd_push    = cmd_valid & r_cmd_ready;
    assign w_cmd_pop     = w_wr_go;
    assign w_rep_push    = (r_state == S_RD_STROBE) & w_end_strobe;
    assign w_rep_pop     = rep_pop & r_rep_valid;
    assign w_rep_rp_n    = r_rep_rp + RPW'(w_rep_pop);
    assign w_rep_cnt_n   = r_rep_cnt + RCW'(w_rep_push) - RCW'(w_rep_pop);

    // Next command occupancy; a flush keeps only a same-cycle push
    always_comb begin
        w_cmd_cnt_n = r_cmd_cnt + CCW'(w_cmd_push) - CCW'(w_cmd_pop);
        if (w_flush) begin
            w_cmd_cnt_n = CCW'(w_cmd_push);
        end
    end

    // Head of reply FIFO after this cycle, bypassing a push into an emptied FIFO
    always_comb begin
        w_rep_head_n = r_rep_mem[w_rep_rp_n];
        if (w_rep_push && (r_rep_wp == w_rep_rp_n)) begin
            w_rep_head_n = Din68k;
        end
    end

    // Two-flop synchronizers for the 6502-side flags
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_buf_s1 <= 1'b0;
            r_buf_s2 <= 1'b0;
            r_int_s1 <= 1'b1;
            r_int_s2 <= 1'b1;
        end else begin
            r_buf_s1 <= ctrl_SNDBUF;
            r_buf_s2 <= r_buf_s1;
            r_int_s1 <= SNDINT_b;
            r_int_s2 <= r_int_s1;
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk100) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wp] <= cmd_data;
        end
    end

    // Command FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_cmd_wp    <= '0;
            r_cmd_rp    <= '0;
            r_cmd_cnt   <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_cmd_wp    <= r_cmd_wp + CPW'(w_cmd_push);
            r_cmd_rp    <= w_flush ? r_cmd_wp : r_cmd_rp + CPW'(w_cmd_pop);
            r_cmd_cnt   <= w_cmd_cnt_n;
            r_cmd_ready <= (w_cmd_cnt_n != CCW'(CMD_DEPTH));
        end
    end

    // Reply FIFO storage
    always_ff @(posedge clk100) begin
        if (w_rep_push) begin
            r_rep_mem[r_rep_wp] <= Din68k;
        end
    end

    // Reply FIFO pointers, occupancy and registered head/valid
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_rep_wp    <= '0;
            r_rep_rp    <= '0;
            r_rep_cnt   <= '0;
            r_rep_valid <= 1'b0;
            r_rep_data  <= 8'h00;
        end else begin
            r_rep_wp    <= r_rep_wp + RPW'(w_rep_push);
            r_rep_rp    <= w_rep_rp_n;
            r_rep_cnt   <= w_rep_cnt_n;
            r_rep_valid <= (w_rep_cnt_n != '0);
            r_rep_data  <= w_rep_head_n;
        end
    end

    // Sequencer: reply-first arbitration, strobe timing and recovery
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dout  <= 8'h00;
            r_wr_b  <= 1'b1;
            r_rd_b  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rd_go) begin
                        r_state <= S_RD_STROBE;
                        r_rd_b  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (w_wr_go) begin
                        r_state <= S_WR_SETUP;
                        r_dout  <= r_cmd_mem[r_cmd_rp];
                        r_busy  <= 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    if (w_end_setup) begin
                        r_state <= S_WR_STROBE;
                        r_wr_b  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WR_STROBE: begin
                    if (w_end_strobe) begin
                        r_state <= S_RECOVER;
                        r_wr_b  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RD_STROBE: begin
                    if (w_end_strobe) begin
                        r_state <= S_RECOVER;
                        r_rd_b  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (w_end_recover) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_wr_b  <= 1'b1;
                    r_rd_b  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SND_HOST_TIMEOUT_EN
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
    logic          w_to_run, w_to_hit;

    assign w_to_run = w_idle & (r_cmd_cnt != '0) & r_buf_s2;
    assign w_to_hit = w_to_run & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_flush  = w_to_hit;

    // Watchdog on a command stuck behind an occupied latch; set beats clear
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_to_run || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end else if (err_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign cmd_timeout = r_timeout;
`else
    logic [TW-1:0] w_unused_to;
    logic          w_unused_clr;

    assign w_unused_to  = '0;
    assign w_unused_clr = err_clr;
    assign w_flush      = 1'b0;
    assign cmd_timeout  = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rep_data  = r_rep_data;
    assign rep_valid = r_rep_valid;
    assign Dout68k   = r_dout;
    assign SNDWR_b   = r_wr_b;
    assign SNDRD_b   = r_rd_b;
    assign busy      = r_busy;

endmodule

// File: tb/tb_snd_host_port.sv
// tb_snd_host_port: vector table, hand sequences and randomized 6502 model.
// Covers the SND_HOST_TIMEOUT_EN watchdog when that macro is defined.
module tb_snd_host_port;

`ifdef SND_HOST_TIMEOUT_EN
    localparam int TB_TO = 100;
`else
    localparam int TB_TO = 65535;
`endif
    localparam int STROBE = 8;

    logic       clk100 = 1'b0;
    logic       rst_b;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rep_data;
    logic       rep_valid;
    logic       rep_pop;
    logic [7:0] Dout68k;
    logic [7:0] Din68k;
    logic       SNDWR_b;
    logic       SNDRD_b;
    logic       ctrl_SNDBUF;
    logic       SNDINT_b;
    logic       busy;
    logic       cmd_timeout;
    logic       err_clr;

    int total = 0;
    int bad   = 0;
    logic p_wr = 1'b1;
    logic p_rd = 1'b1;

    snd_host_port #(
        .CMD_DEPTH(4), .REP_DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(STROBE),
        .RECOVER_CYC(32), .TIMEOUT_CYC(TB_TO)
    ) dut (
        .clk100(clk100), .rst_b(rst_b),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rep_data(rep_data), .rep_valid(rep_valid), .rep_pop(rep_pop),
        .Dout68k(Dout68k), .Din68k(Din68k),
        .SNDWR_b(SNDWR_b), .SNDRD_b(SNDRD_b),
        .ctrl_SNDBUF(ctrl_SNDBUF), .SNDINT_b(SNDINT_b),
        .busy(busy), .cmd_timeout(cmd_timeout), .err_clr(err_clr)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        p_wr = SNDWR_b;
        p_rd = SNDRD_b;
        @(posedge clk100);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: return SNDWR_b;
            1: return SNDRD_b;
            2: return rep_valid;
            3: return busy;
            4: return cmd_timeout;
            default: return SNDWR_b & SNDRD_b;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic lvl, input int lim,
                            input string nm, output int n);
        n = 0;
        while (n < lim) begin
            tick();
            n++;
            if (sel(which) == lvl) return;
        end
        total++;
        bad++;
        $display("FAIL %s: no level %0d within %0d cycles", nm, lvl, lim);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = 8'h00;
        rep_pop = 1'b0;
        err_clr = 1'b0;
        SNDINT_b = 1'b1;
        ctrl_SNDBUF = 1'b0;
        Din68k = 8'h00;
        repeat (3) tick();
        rst_b = 1'b1;
        repeat (2) tick();
    endtask

    task automatic push1(input logic [7:0] d);
        cmd_data = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_wr"}, SNDWR_b, 1);
        chk({pfx, "_rd"}, SNDRD_b, 1);
        chk({pfx, "_dout"}, Dout68k, 8'h00);
        chk({pfx, "_ready"}, cmd_ready, 1);
        chk({pfx, "_rvalid"}, rep_valid, 0);
        chk({pfx, "_rdata"}, rep_data, 8'h00);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_timeout"}, cmd_timeout, 0);
    endtask

    // Strobe-shape monitor: width, data hold, setup, mutual exclusion
    int         mwl = 0, mrl = 0;
    logic       mpw = 1'b1, mpr = 1'b1;
    logic [7:0] d1 = 8'h00, d2 = 8'h00, mdo = 8'h00;
    always @(negedge clk100) begin
        if (!rst_b) begin
            mwl = 0;
            mrl = 0;
            mpw = 1'b1;
            mpr = 1'b1;
        end else begin
            if (!SNDWR_b || !SNDRD_b) chk("no_overlap", SNDWR_b | SNDRD_b, 1);
            if (!SNDWR_b) begin
                if (mpw) begin
                    chk("wr_setup1", d1, Dout68k);
                    chk("wr_setup2", d2, Dout68k);
                    mdo = Dout68k;
                end else begin
                    chk("wr_hold", Dout68k, mdo);
                end
                mwl++;
            end else if (!mpw) begin
                chk("wr_width", mwl, STROBE);
                mwl = 0;
            end
            if (!SNDRD_b) begin
                mrl++;
            end else if (!mpr) begin
                chk("rd_width", mrl, STROBE);
                mrl = 0;
            end
            mpw = SNDWR_b;
            mpr = SNDRD_b;
            d2 = d1;
            d1 = Dout68k;
        end
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_ready;
        logic       e_busy;
        logic       e_wr;
    } vec_t;

    initial begin
        vec_t tv[7];
        int n, nwr, wrc, rdc;
        logic [7:0] wd[8];
        int wt[8];
        logic [7:0] exp_rep[4];
        logic [7:0] expq[$], mq[$], emq[$];
        logic [7:0] b, cd, wdat;
        logic cv, pv, rdy, done;
        int hold;

        tv[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        tv[2] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1};
        tv[5] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
        tv[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        do_reset();
        chk_reset_vals("rst");

        // Backpressure table with the latch held occupied
        ctrl_SNDBUF = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            cmd_valid = tv[i].v;
            cmd_data = tv[i].d;
            tick();
            chk($sformatf("tv%0d_ready", i), cmd_ready, tv[i].e_ready);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d_wr", i), SNDWR_b, tv[i].e_wr);
        end
        cmd_valid = 1'b0;
        ctrl_SNDBUF = 1'b0;
        nwr = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (p_wr && !SNDWR_b && nwr < 8) begin
                wd[nwr] = Dout68k;
                wt[nwr] = i;
                nwr++;
            end
        end
        chk("bp_count", nwr, 4);
        for (int k = 0; k < nwr && k < 4; k++) begin
            chk($sformatf("bp_data%0d", k), wd[k], 8'h11 * (k + 1));
            if (k > 0) chk($sformatf("bp_gap%0d", k), (wt[k] - wt[k-1]) >= 43, 1);
        end

        // Single write timing
        do_reset();
        push1(8'hA5);
        chk("sw_wr_hi", SNDWR_b, 1);
        wait_for(0, 1'b0, 20, "sw_fall", n);
        chk("sw_lat", n + 1, 4);
        chk("sw_dout", Dout68k, 8'hA5);
        wait_for(0, 1'b1, 20, "sw_rise", n);
        chk("sw_width", n, 8);
        wait_for(3, 1'b0, 60, "sw_idle", n);
        chk("sw_recover", n, 32);
        chk("sw_dout_hold", Dout68k, 8'hA5);

        // Reply drain
        do_reset();
        Din68k = 8'h3C;
        SNDINT_b = 1'b0;
        wait_for(1, 1'b0, 20, "rp_fall", n);
        chk("rp_lat", n, 3);
        SNDINT_b = 1'b1;
        chk("rp_novalid", rep_valid, 0);
        wait_for(1, 1'b1, 20, "rp_rise", n);
        chk("rp_width", n, 8);
        chk("rp_valid", rep_valid, 1);
        chk("rp_data", rep_data, 8'h3C);
        rep_pop = 1'b1;
        tick();
        rep_pop = 1'b0;
        chk("rp_popped", rep_valid, 0);

        // Priority, then reply FIFO full with writes still flowing
        do_reset();
        ctrl_SNDBUF = 1'b1;
        repeat (3) tick();
        push1(8'hCC);
        repeat (3) tick();
        Din68k = 8'hD1;
        SNDINT_b = 1'b0;
        ctrl_SNDBUF = 1'b0;
        wait_for(5, 1'b0, 20, "pr_first", n);
        chk("pr_rd_first", SNDRD_b, 0);
        chk("pr_wr_wait", SNDWR_b, 1);
        SNDINT_b = 1'b1;
        wait_for(0, 1'b0, 100, "pr_wr", n);
        chk("pr_wr_data", Dout68k, 8'hCC);
        chk("pr_rep", rep_data, 8'hD1);
        rep_pop = 1'b1;
        tick();
        rep_pop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            Din68k = 8'h40 + 8'(k);
            SNDINT_b = 1'b0;
            wait_for(1, 1'b0, 100, "fill_fall", n);
            SNDINT_b = 1'b1;
            wait_for(1, 1'b1, 20, "fill_rise", n);
        end
        wait_for(3, 1'b0, 60, "fill_idle", n);
        Din68k = 8'h99;
        SNDINT_b = 1'b0;
        cmd_data = 8'h77;
        cmd_valid = 1'b1;
        wrc = 0;
        rdc = 0;
        wdat = 8'h00;
        for (int i = 0; i < 120; i++) begin
            tick();
            cmd_valid = 1'b0;
            if (p_wr && !SNDWR_b) begin
                wrc++;
                wdat = Dout68k;
            end
            if (p_rd && !SNDRD_b) rdc++;
        end
        chk("full_wr_cnt", wrc, 1);
        chk("full_wr_data", wdat, 8'h77);
        chk("full_no_rd", rdc, 0);
        chk("full_head", rep_data, 8'h40);
        rep_pop = 1'b1;
        tick();
        rep_pop = 1'b0;
        chk("full_head2", rep_data, 8'h41);
        wait_for(1, 1'b0, 100, "full_resume", n);
        SNDINT_b = 1'b1;
        wait_for(1, 1'b1, 20, "full_resume_rise", n);
        exp_rep = '{8'h41, 8'h42, 8'h43, 8'h99};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_v%0d", k), rep_valid, 1);
            chk($sformatf("drain_d%0d", k), rep_data, exp_rep[k]);
            rep_pop = 1'b1;
            tick();
            rep_pop = 1'b0;
        end
        chk("drain_empty", rep_valid, 0);

        // Reset in the middle of a write strobe
        do_reset();
        push1(8'h5A);
        wait_for(0, 1'b0, 20, "mr_fall", n);
        tick();
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk_reset_vals("mr");
        tick();
        tick();
        rst_b = 1'b1;
        wrc = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (p_wr && !SNDWR_b) wrc++;
        end
        chk("mr_lost", wrc, 0);

        // Randomized traffic against a queue-level mailbox model
        do_reset();
        hold = 0;
        done = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            cv = (i < 4000) && ($urandom_range(0, 2) == 0);
            cd = 8'($urandom);
            pv = (i < 4000) ? ($urandom_range(0, 3) == 0) : 1'b1;
            rdy = cmd_ready;
            cmd_valid = cv;
            cmd_data = cd;
            rep_pop = pv;
            tick();
            if (cv && rdy) expq.push_back(cd);
            if (pv && mq.size() > 0) b = mq.pop_front();
            if (p_rd && !SNDRD_b) SNDINT_b = 1'b1;
            if (!p_rd && SNDRD_b) begin
                chk("rnd_rd_req", emq.size() != 0, 1);
                if (emq.size() > 0) mq.push_back(emq.pop_front());
                if (emq.size() > 0) begin
                    Din68k = emq[0];
                    SNDINT_b = 1'b0;
                end
            end
            if (p_wr && !SNDWR_b) begin
                chk("rnd_wr_req", expq.size() != 0, 1);
                chk("rnd_wr_buf", ctrl_SNDBUF, 0);
                if (expq.size() > 0) begin
                    b = expq.pop_front();
                    chk("rnd_wr_data", Dout68k, b);
                end
            end
            if (!p_wr && SNDWR_b) begin
                hold = $urandom_range(0, 50);
                ctrl_SNDBUF = (hold > 0);
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) ctrl_SNDBUF = 1'b0;
            end
            chk("rnd_rvalid", rep_valid, mq.size() != 0);
            if (mq.size() > 0) chk("rnd_rdata", rep_data, mq[0]);
            if (i < 4000 && emq.size() == 0 && $urandom_range(0, 39) == 0) begin
                emq.push_back(8'($urandom));
                Din68k = emq[0];
                SNDINT_b = 1'b0;
            end
            if (i >= 4000 && expq.size() == 0 && emq.size() == 0 &&
                mq.size() == 0 && !busy && hold == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL rnd_drain: cmds=%0d emu=%0d reps=%0d left", expq.size(), emq.size(), mq.size());
        end
        cmd_valid = 1'b0;
        rep_pop = 1'b0;

`ifdef SND_HOST_TIMEOUT_EN
        do_reset();
        ctrl_SNDBUF = 1'b1;
        repeat (3) tick();
        push1(8'hEE);
        chk("to_pending", cmd_timeout, 0);
        wait_for(4, 1'b1, 150, "to_set", n);
        chk("to_ready", cmd_ready, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", cmd_timeout, 0);
        ctrl_SNDBUF = 1'b0;
        wrc = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (p_wr && !SNDWR_b) wrc++;
        end
        chk("to_flushed", wrc, 0);
`else
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_off", cmd_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snd_host_port.md
# snd_host_port

68k-side engine for the sound mailbox: takes command bytes from a local producer, writes them into the 6502's command latch with correctly timed `SNDWR_b` strobes, and drains reply bytes with `SNDRD_b` strobes when the 6502 raises `SNDINT_b`. It sits between a 68k-side sequencer (or test harness) and `io_interface`. It replaces hand-driven `SNDWR_b`/`SNDRD_b` ties with a flow-controlled, buffered initiator.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `REP_DEPTH`, 4: reply FIFO entries (power of 2, ≥2).
- `SETUP_CYC`, 2: clk100 cycles `Dout68k` is stable before `SNDWR_b` falls.
- `STROBE_CYC`, 8: clk100 cycles `SNDWR_b`/`SNDRD_b` are held low.
- `RECOVER_CYC`, 32: idle cycles after any strobe before flags are re-evaluated.
- `TIMEOUT_CYC`, 65535: watchdog limit; used only with `SND_HOST_TIMEOUT_EN`.

Ports:
- `clk100`  in  1  system clock; the block's only clock.
- `rst_b`  in  1  asynchronous, active-low reset.
- `cmd_data`  in  8  command byte to send.
- `cmd_valid`  in  1  push request; a push is accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_ready`  out  1  command FIFO not full.
- `rep_data`  out  8  head of reply FIFO.
- `rep_valid`  out  1  reply FIFO not empty.
- `rep_pop`  in  1  consumes the head when `rep_valid`; ignored when empty.
- `Dout68k`  out  8  data to `io_interface`.
- `Din68k`  in  8  reply data from `io_interface`.
- `SNDWR_b`  out  1  active-low write strobe to the command latch.
- `SNDRD_b`  out  1  active-low read strobe for the reply latch.
- `ctrl_SNDBUF`  in  1  high = command latch occupied (6502 has not read it).
- `SNDINT_b`  in  1  low = reply byte pending.
- `busy`  out  1  FSM is not in IDLE.
- `cmd_timeout`  out  1  sticky watchdog flag; tied 0 without the macro.
- `err_clr`  in  1  clears `cmd_timeout`.

## Operation
- `ctrl_SNDBUF` and `SNDINT_b` pass through 2-flop synchronizers. Decisions use the synchronized values only.
- FSM states: IDLE, WR_SETUP, WR_STROBE, RD_STROBE, RECOVER.
- IDLE decision order:
  1. If a reply is pending (synced `SNDINT_b`=0) and the reply FIFO is not full, go to RD_STROBE. Replies take priority, so the 6502 never stalls on an unread reply.
  2. Otherwise, if the command FIFO is not empty and synced `ctrl_SNDBUF`=0, pop the head into the output register and go to WR_SETUP.
  3. Otherwise, stay in IDLE.
- If the reply FIFO is full while a reply is pending, no read is issued and the reply waits in the latch. Writes are still allowed.
- WR_SETUP: `Dout68k` = popped byte, held for `SETUP_CYC` cycles, then go to WR_STROBE.
- WR_STROBE: `SNDWR_b`=0 for `STROBE_CYC` cycles. `Dout68k` stays unchanged. Then go to RECOVER.
- RD_STROBE: `SNDRD_b`=0 for `STROBE_CYC` cycles. `Din68k` is sampled on the last low cycle and pushed to the reply FIFO. Then go to RECOVER.
- RECOVER: both strobes high for `RECOVER_CYC` cycles, then go to IDLE. `Dout68k` holds its last value.
- `SNDWR_b` and `SNDRD_b` are never low at the same time.
- FIFO counters are `$clog2(DEPTH)+1` bits wide; pointers wrap modulo DEPTH.
- A simultaneous push and pop on the same FIFO is legal at every occupancy, including full and empty boundaries. When the command FIFO is full, `cmd_ready`=0 and a push is ignored.

## Timing
- Reset values: `SNDWR_b`=1, `SNDRD_b`=1, `Dout68k`=8'h00, `cmd_ready`=1, `rep_valid`=0, `rep_data`=8'h00, `busy`=0, `cmd_timeout`=0. FSM = IDLE, both FIFOs empty, synchronizers reset to the idle state (`ctrl_SNDBUF`=0, `SNDINT_b`=1).
- Reset asserted mid-strobe releases the strobe asynchronously. The in-flight byte is lost.
- Command latency, from an accepted push into an empty FIFO with the latch free to `SNDWR_b` falling: 1 (FIFO) + 1 (IDLE decision) + `SETUP_CYC` cycles.
- Per-byte period: write = `SETUP_CYC+STROBE_CYC+RECOVER_CYC+1`; read = `STROBE_CYC+RECOVER_CYC+1`.
- A reply appears on `rep_valid` 1 cycle after the RD_STROBE sample.
- All outputs are registered.

## Configuration
- `SND_HOST_TIMEOUT_EN` defined:
  - A counter runs while in IDLE with the command FIFO non-empty and synced `ctrl_SNDBUF`=1.
  - On reaching `TIMEOUT_CYC`, the counter sets `cmd_timeout`, flushes the command FIFO and resets itself.
  - The counter clears whenever that condition is false.
  - `err_clr` clears `cmd_timeout`. If `err_clr` and a new timeout occur in the same cycle, set wins.
- Not defined: no counter, `cmd_timeout` tied 0, `err_clr` ignored.

## Test plan
- Single write: push 8'hA5 with `ctrl_SNDBUF`=0 → `Dout68k`=A5 for 2 cycles, then `SNDWR_b` low for exactly 8 cycles, then 32 recovery cycles; `busy` returns to 0.
- Backpressure: hold `ctrl_SNDBUF`=1 and push 5 bytes → `cmd_ready` drops after 4 accepts and no `SNDWR_b`. Release → bytes 1–4 are written in order, each at least 43 cycles apart.
- Reply drain: drive `SNDINT_b`=0 with `Din68k`=8'h3C → `SNDRD_b` low for 8 cycles, then `rep_valid`=1, `rep_data`=3C; `rep_pop` → `rep_valid`=0.
- Priority and full: with a command and a reply both pending, the read is issued first. With the reply FIFO full (4 entries) and `SNDINT_b`=0 → no `SNDRD_b`, writes continue. One pop → the read resumes.
- Reset mid-strobe: assert `rst_b`=0 during WR_STROBE → `SNDWR_b`=1 immediately and all outputs at reset values.
- `SND_HOST_TIMEOUT_EN` with `TIMEOUT_CYC`=100: command pending and `ctrl_SNDBUF` stuck 1 → `cmd_timeout`=1 within about 100 cycles, FIFO flushed, `cmd_ready`=1; `err_clr` → 0.
